// File: rtl/rrc_rdsched.sv
// Read scheduler for one ReRAM macro port.
// Two requesters are arbitrated round-robin. The winner's address is split into XADR/YADR and
// driven under CE. AE is then strobed, and READ is held until RDONE arrives or the wait times
// out. The captured DOUT/DOUT_CR is returned as a one-cycle pulse to the winning port.
// Every output is registered. The output registers load from the next-state decode, so each
// output is aligned with the state it belongs to.
module rrc_rdsched #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 144,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned AE_CYC    = 2,
  parameter int unsigned TMO       = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [AW-1:0] req_adr0,
  input  logic [AW-1:0] req_adr1,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_dat,
  output logic [1:0]    rsp_cr,
  output logic          rsp_err,
  output logic          busy,
  output logic          rr_ce,
  output logic          rr_ae,
  output logic          rr_read,
  output logic [AW-6:0] rr_xadr,
  output logic [4:0]    rr_yadr,
  input  logic [DW-1:0] rr_dout,
  input  logic [1:0]    rr_dout_cr,
  input  logic          rr_rdone
);

  localparam int unsigned MaxSa  = (SETUP_CYC > AE_CYC) ? SETUP_CYC : AE_CYC;
  localparam int unsigned CntMax = (TMO > MaxSa) ? TMO : MaxSa;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StSetup,
    StStrobe,
    StWait,
    StDone
  } state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic            r_port, w_port_d;
  logic            r_last, w_last_d;
  logic [1:0]      r_req_ready, w_req_ready_d;
  logic [1:0]      r_rsp_valid, w_rsp_valid_d;
  logic [DW-1:0]   r_rsp_dat, w_rsp_dat_d;
  logic [1:0]      r_rsp_cr, w_rsp_cr_d;
  logic            r_rsp_err, w_rsp_err_d;
  logic            r_busy, w_busy_d;
  logic            r_ce, w_ce_d;
  logic            r_ae, w_ae_d;
  logic            r_read, w_read_d;
  logic [AW-6:0]   r_xadr, w_xadr_d;
  logic [4:0]      r_yadr, w_yadr_d;
  logic            w_gnt;
  logic [AW-1:0]   w_adr;
  logic [1:0]      w_port_oh;

  // A sole requester wins; on a tie the port that was not granted last time wins.
  assign w_gnt     = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign w_adr     = r_port ? req_adr1 : req_adr0;
  assign w_port_oh = w_port_d ? 2'b10 : 2'b01;

  // Next-state and next-output decode.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_port_d    = r_port;
    w_last_d    = r_last;
    w_xadr_d    = r_xadr;
    w_yadr_d    = r_yadr;
    w_rsp_dat_d = r_rsp_dat;
    w_rsp_cr_d  = r_rsp_cr;
    w_rsp_err_d = 1'b0;

    case (r_state)
      StIdle: begin
        if (|req_valid) begin
          w_state_d = StGrant;
          w_port_d  = w_gnt;
          w_last_d  = w_gnt;
        end
      end
      StGrant: begin
        // The requester holds its address through the ready cycle, so latch it here.
        w_state_d             = StSetup;
        w_cnt_d               = CW'(1);
        {w_xadr_d, w_yadr_d}  = w_adr;
      end
      StSetup: begin
        if (r_cnt == CW'(SETUP_CYC)) begin
          w_state_d = StStrobe;
          w_cnt_d   = CW'(1);
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StStrobe: begin
        if (r_cnt == CW'(AE_CYC)) begin
          w_state_d = StWait;
          w_cnt_d   = CW'(1);
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StWait: begin
        // RDONE takes priority, so a completion on the last allowed cycle is a success.
        if (rr_rdone) begin
          w_state_d   = StDone;
          w_rsp_dat_d = rr_dout;
          w_rsp_cr_d  = rr_dout_cr;
        end else if (r_cnt == CW'(TMO)) begin
          w_state_d   = StDone;
          w_rsp_dat_d = '0;
          w_rsp_cr_d  = 2'b00;
          w_rsp_err_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_req_ready_d = (w_state_d == StGrant) ? w_port_oh : 2'b00;
    w_rsp_valid_d = (w_state_d == StDone) ? w_port_oh : 2'b00;
    w_busy_d      = (w_state_d != StIdle);
    w_ce_d        = (w_state_d == StSetup) || (w_state_d == StStrobe) || (w_state_d == StWait);
    w_ae_d        = (w_state_d == StStrobe);
    w_read_d      = (w_state_d == StWait);
  end

  // State and registered outputs; reset clears the macro strobes asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_port      <= 1'b0;
      r_last      <= 1'b1;
      r_req_ready <= 2'b00;
      r_rsp_valid <= 2'b00;
      r_rsp_dat   <= '0;
      r_rsp_cr    <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_ce        <= 1'b0;
      r_ae        <= 1'b0;
      r_read      <= 1'b0;
      r_xadr      <= '0;
      r_yadr      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_port      <= w_port_d;
      r_last      <= w_last_d;
      r_req_ready <= w_req_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_dat   <= w_rsp_dat_d;
      r_rsp_cr    <= w_rsp_cr_d;
      r_rsp_err   <= w_rsp_err_d;
      r_busy      <= w_busy_d;
      r_ce        <= w_ce_d;
      r_ae        <= w_ae_d;
      r_read      <= w_read_d;
      r_xadr      <= w_xadr_d;
      r_yadr      <= w_yadr_d;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_cr    = r_rsp_cr;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign rr_ce     = r_ce;
  assign rr_ae     = r_ae;
  assign rr_read   = r_read;
  assign rr_xadr   = r_xadr;
  assign rr_yadr   = r_yadr;

endmodule
